memory_access: RTL
==================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 prev_clk_en  input  1  upstream (execute) stage holds a valid instruction.
REQ-004 prev_opcode  input  3  one-hot {system, store, load} from execute.
REQ-005 prev_funct3  input  3  access size/sign (LB/LH/LW/LBU/LHU/SB/SH/SW encodings).
REQ-006 prev_addr  input  32  effective address (ALU result).
REQ-007 prev_rs2  input  32  store data.
REQ-008 prev_rd / prev_rd_w_en / prev_rd_wdata / prev_pc  input  5/1/32/32  destination, write enable, ALU result, next-PC from execute.
REQ-009 flush  input  1  from writeback; kill the instruction held in this stage.
REQ-010 stall  output  1  hold upstream stages.
REQ-011 clk_en  output  1  writeback-stage valid (writeback's prev_clk_en).
REQ-012 opcode_load / opcode_system / funct3  output  1/1/3  registered copies for writeback.
REQ-013 rd / rd_w_en / rd_wdata / pc  output  5/1/32/32  registered copies of prev_* values.
REQ-014 data_load  output  32  aligned, sign/zero-extended load result.
REQ-015 mem_req / mem_we  output  1/1  data-bus request strobe, write enable.
REQ-016 mem_addr / mem_wdata / mem_wsel  output  32/32/4  word address (bits[1:0]=0), lane-replicated data, byte lanes.
REQ-017 mem_ack / mem_rdata  input  1/32  one-cycle completion pulse, read word valid with ack.

Function
REQ-018 FSM states IDLE and WAIT_ACK; in IDLE an accepted instruction (prev_clk_en=1, stall=0) is registered on the next edge.
REQ-019 Non-memory instruction: outputs registered in 1 cycle, clk_en=1, mem_req stays 0, state stays IDLE.
REQ-020 Load/store accepted: next edge mem_req=1, mem_we=store, mem_addr={prev_addr[31:2],2'b00}, state WAIT_ACK, clk_en=0.
REQ-021 Store lanes: SB wdata={4{rs2[7:0]}}, wsel=4'b0001<<addr[1:0]; SH wdata={2{rs2[15:0]}}, wsel=4'b0011<<{addr[1],1'b0}; SW wdata=rs2, wsel=4'b1111; loads drive wsel per size identically.
REQ-022 In WAIT_ACK: stall=1 combinationally, request fields held stable; mem_ack=1 drops mem_req next edge, pulses clk_en=1 for one cycle, returns to IDLE.
REQ-023 Load formatting selects byte/half of mem_rdata by registered addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through; data_load captured on the ack edge.
REQ-024 Minimum load/store latency 2 cycles (accept edge to clk_en pulse, ack in first WAIT_ACK cycle); no upper bound.
REQ-025 flush=1 clears clk_en and rd_w_en next edge; flush during WAIT_ACK keeps mem_req asserted until ack (no bus abort), result discarded.
REQ-026 Accept and ack never coincide: stall blocks new acceptance while WAIT_ACK; mem_ack in IDLE ignored.

Reset
REQ-027 rst=1: state IDLE, mem_req=0, mem_we=0, clk_en=0, rd_w_en=0, all data outputs 0, misaligned=0, including mid-transaction (pending ack ignored afterwards).

Configuration
REQ-028 MEMACC_MISALIGN_EXC_EN defined: port misaligned output 1 exists; LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 issue no bus request, pass through in 1 cycle with misaligned=1, rd_w_en=0.
REQ-029 MEMACC_MISALIGN_EXC_EN undefined: no misaligned port; low address bits below access size ignored (access forced to naturally aligned lanes).

Structure
REQ-030 funct3 load/store encodings and FSM state constants live in rv32i_header.vh; optional sub-module mem_load_align (combinational lane select/extend).

Verification
REQ-031 SW addr=0x104 rs2=0xDEADBEEF, ack after 3 cycles -> mem_addr=0x104, wsel=4'b1111, stall high 3 cycles, one clk_en pulse.
REQ-032 LB addr=0x103, rdata=0x80FF_FF7F -> data_load=0xFFFFFF80; LBU same -> 0x00000080; LH addr=0x102 -> 0xFFFF80FF.
REQ-033 SB addr=0x202 rs2=0x000000AB -> wdata=0xABABABAB, wsel=4'b0100; ADD result 0x55 -> rd_wdata=0x55 one cycle later, mem_req=0.
REQ-034 flush asserted cycle after LW issue, ack 2 cycles later -> mem_req held until ack, clk_en/rd_w_en stay 0; rst during WAIT_ACK -> mem_req=0 next edge, state IDLE.

Source files
------------

// File: rtl/memory_access_pkg.sv
// Shared constants and lane helpers for the memory-access pipeline stage:
// funct3 load/store encodings, FSM state constants and byte-lane functions.
package memory_access_pkg;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_ACK = 1'b1;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Bit positions inside the one-hot {system, store, load} opcode.
  localparam int OP_LOAD   = 0;
  localparam int OP_STORE  = 1;
  localparam int OP_SYSTEM = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  function automatic acc_size_e access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  // Byte offset of the access once forced onto its natural alignment.
  function automatic logic [1:0] lane_offset(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (access_size(f3))
      SZ_BYTE: return addr_lo;
      SZ_HALF: return {addr_lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (access_size(f3))
      SZ_BYTE: return 4'b0001 << addr_lo;
      SZ_HALF: return 4'b0011 << {addr_lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] rs2);
    case (access_size(f3))
      SZ_BYTE: return {4{rs2[7:0]}};
      SZ_HALF: return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction

  function automatic logic misaligned_access(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (access_size(f3))
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_mem_load_align.sv
// Combinational load formatter: picks the byte/half/word lane of the read
// word by the low address bits and sign- or zero-extends it to 32 bits.
module mem_load_align
  import memory_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [1:0]         off;
  logic [31:0]        shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] ext_s;

  always_comb begin
    off     = lane_offset(funct3, addr_lo);
    shifted = rdata >> {off, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    ext_s   = 32'sd0;
    data    = shifted;
    case (access_size(funct3))
      SZ_BYTE: begin
        ext_s = byte_s;
        data  = funct3[2] ? {24'd0, shifted[7:0]} : ext_s;
      end
      SZ_HALF: begin
        ext_s = half_s;
        data  = funct3[2] ? {16'd0, shifted[15:0]} : ext_s;
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// RV32I memory-access pipeline stage: issues data-bus requests for loads and
// stores and stalls until ack. Optional macro MEMACC_MISALIGN_EXC_EN adds the
// misaligned output and turns misaligned accesses into bus-less pass-throughs.
module memory_access
  import memory_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        prev_clk_en,
  input  logic [2:0]  prev_opcode,
  input  logic [2:0]  prev_funct3,
  input  logic [31:0] prev_addr,
  input  logic [31:0] prev_rs2,
  input  logic [4:0]  prev_rd,
  input  logic        prev_rd_w_en,
  input  logic [31:0] prev_rd_wdata,
  input  logic [31:0] prev_pc,
  input  logic        flush,
  output logic        stall,
  output logic        clk_en,
  output logic        opcode_load,
  output logic        opcode_system,
  output logic [2:0]  funct3,
  output logic [4:0]  rd,
  output logic        rd_w_en,
  output logic [31:0] rd_wdata,
  output logic [31:0] pc,
  output logic [31:0] data_load,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wsel,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef MEMACC_MISALIGN_EXC_EN
  ,
  output logic        misaligned
`endif
);

  logic [0:0]  state_p1;
  logic        killed_p1;
  logic [1:0]  addr_lo_p1;
  logic        accept_p0;
  logic        is_mem_p0;
  logic        mis_p0;
  logic [31:0] load_data_p1;

  assign stall     = (state_p1 == ST_WAIT_ACK);
  assign accept_p0 = prev_clk_en & ~stall & ~flush;
  assign is_mem_p0 = prev_opcode[OP_LOAD] | prev_opcode[OP_STORE];

`ifdef MEMACC_MISALIGN_EXC_EN
  assign mis_p0 = is_mem_p0 & misaligned_access(prev_funct3, prev_addr[1:0]);
`else
  assign mis_p0 = 1'b0;
`endif

  // Formatting runs off the registered funct3/offset so it lines up with rdata at ack.
  mem_load_align u_load_align (
    .funct3  (funct3),
    .addr_lo (addr_lo_p1),
    .rdata   (mem_rdata),
    .data    (load_data_p1)
  );

  // ---- Stage p0 -> p1: accept from execute, issue bus request, retire on ack ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1      <= ST_IDLE;
      killed_p1     <= 1'b0;
      addr_lo_p1    <= 2'b00;
      clk_en        <= 1'b0;
      opcode_load   <= 1'b0;
      opcode_system <= 1'b0;
      funct3        <= 3'b000;
      rd            <= 5'd0;
      rd_w_en       <= 1'b0;
      rd_wdata      <= 32'd0;
      pc            <= 32'd0;
      data_load     <= 32'd0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 32'd0;
      mem_wdata     <= 32'd0;
      mem_wsel      <= 4'd0;
`ifdef MEMACC_MISALIGN_EXC_EN
      misaligned    <= 1'b0;
`endif
    end else begin
      case (state_p1)
        ST_IDLE: begin
          clk_en <= 1'b0;
`ifdef MEMACC_MISALIGN_EXC_EN
          misaligned <= 1'b0;
`endif
          if (flush) rd_w_en <= 1'b0;
          if (accept_p0) begin
            opcode_load   <= prev_opcode[OP_LOAD];
            opcode_system <= prev_opcode[OP_SYSTEM];
            funct3        <= prev_funct3;
            rd            <= prev_rd;
            rd_wdata      <= prev_rd_wdata;
            pc            <= prev_pc;
            addr_lo_p1    <= prev_addr[1:0];
            killed_p1     <= 1'b0;
`ifdef MEMACC_MISALIGN_EXC_EN
            misaligned    <= mis_p0;
`endif
            if (is_mem_p0 && !mis_p0) begin
              mem_req   <= 1'b1;
              mem_we    <= prev_opcode[OP_STORE];
              mem_addr  <= {prev_addr[31:2], 2'b00};
              mem_wsel  <= lane_sel(prev_funct3, prev_addr[1:0]);
              mem_wdata <= lane_data(prev_funct3, prev_rs2);
              rd_w_en   <= prev_rd_w_en;
              state_p1  <= ST_WAIT_ACK;
            end else begin
              clk_en  <= 1'b1;
              rd_w_en <= prev_rd_w_en & ~mis_p0;
            end
          end
        end
        default: begin
          // A flushed access still runs to completion on the bus; only its result is dropped.
          if (flush) begin
            killed_p1 <= 1'b1;
            rd_w_en   <= 1'b0;
          end
          if (mem_ack) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            clk_en   <= ~(killed_p1 | flush);
            state_p1 <= ST_IDLE;
            if (opcode_load) data_load <= load_data_p1;
            if (killed_p1 | flush) rd_w_en <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
